shift_adder: RTL and testbench
==============================

// Module: shift_adder
// PURPOSE
//  Bit-serial WIDTH-bit adder built from two right-shift operand registers, a sum shift register and a carry flip-flop.
//  Operands load in parallel, then one LSB pair is added per clock, with the sum bit shifted in at the sum MSB.
//  After WIDTH shifts, op holds (a+b) mod 2^WIDTH and carry holds the carry-out.
//  Used as a low-area arithmetic datapath element; operand registers are exposed for observation.
// PARAMETERS
//  WIDTH  16  operand/sum width in bits (>=2)
// PORTS
//  clk         in   1      rising-edge clock; single clock domain
//  reset       in   1      asynchronous, active-low reset (0 = reset)
//  load        in   1      synchronous parallel load of a/b; starts an addition
//  a           in   WIDTH  operand A (sampled when load=1)
//  b           in   WIDTH  operand B (sampled when load=1)
//  contents_a  out  WIDTH  current operand-A shift register
//  contents_b  out  WIDTH  current operand-B shift register
//  op          out  WIDTH  sum shift register
//  carry       out  1      carry flip-flop: running carry, final carry-out when complete
//  done        out  1      only with SHIFT_ADDER_DONE_EN, see CONFIGURATION
// BEHAVIOUR
//  - All outputs are registered; there is no combinational input-to-output path.
//  - Reset (reset=0, asynchronous): contents_a, contents_b, op and carry clear to 0; bit counter = 0; state IDLE.
//  - States:
//    - IDLE: registers hold.
//    - SHIFT: adding; counter counts 0..WIDTH-1.
//    - DONE: registers hold.
//  - Load: at a rising edge with load=1 (any state):
//    - contents_a<=a, contents_b<=b, op<=0, carry<=0, counter<=0, state<=SHIFT.
//    - Load has priority over shifting, so a load mid-operation aborts and restarts.
//    - load held high reloads every cycle and no shifting occurs.
//  - Shift step: at a rising edge with load=0 in SHIFT:
//    - s = contents_a[0]^contents_b[0]^carry.
//    - carry <= majority(contents_a[0], contents_b[0], carry).
//    - contents_a <= {1'b0, contents_a[WIDTH-1:1]}; contents_b likewise.
//    - op <= {s, op[WIDTH-1:1]}; counter++.
//  - The step with counter=WIDTH-1 is the last: state<=DONE.
//  - Latency: WIDTH clocks after the load edge. Then op=(a+b) mod 2^WIDTH, carry=a+b>>WIDTH, contents_a=contents_b=0.
//  - DONE/IDLE: all registers hold indefinitely (no further shifting) until the next load.
//  - Reset during SHIFT aborts immediately to the reset values; no partial result is retained.
//  - Overflow wraps modulo 2^WIDTH; overflow is reported only via carry.
// CONFIGURATION
//  - SHIFT_ADDER_DONE_EN defined:
//    - Adds 1-bit output port done, registered.
//    - done=1 exactly while in DONE; cleared by reset or load.
//    - done is 0 in IDLE and in SHIFT.
//  - Undefined: the done port and its logic are absent; all other behaviour is identical.
// TESTING
//  - Reset, then load a=16'h38A9, b=16'hBC99, release load, 16 clocks -> op=16'hF542, carry=0, contents_a=contents_b=0.
//  - a=16'hFFFF, b=16'h0001, 16 clocks -> op=16'h0000, carry=1. Hold 5 more clocks -> unchanged.
//  - a=16'h0001, b=16'h0001, after 1 clock -> op=16'h0000, carry=1, contents_a=0, contents_b=0.
//    After 16 clocks -> op=16'h0002, carry=0.
//  - Load a=16'h1234, b=16'h0F0F; after 5 clocks, load a=16'h0001, b=16'h0002; 16 clocks -> op=16'h0003, carry=0.
//  - Drive reset=0 asynchronously mid-shift (between edges) -> all outputs 0 immediately, no shifting until the next load.
//  - With SHIFT_ADDER_DONE_EN: done=0 for clocks 1..15 after load, done=1 after clock 16, done=0 on the next load.

Source files
------------

// File: rtl/shift_adder.sv
// Bit-serial WIDTH-bit adder: two right-shift operand registers feed a full
// adder one LSB pair per clock; the sum bit enters the sum register at its MSB.
// Optional feature macro: SHIFT_ADDER_DONE_EN (adds registered 'done' output).
module shift_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] contents_a,
    output logic [WIDTH-1:0] contents_b,
    output logic [WIDTH-1:0] op,
`ifdef SHIFT_ADDER_DONE_EN
    output logic             done,
`endif
    output logic             carry
);

    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] op_q, op_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sum_bit;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: load wins over shifting; one full-adder step per SHIFT cycle
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_bit = a_q[0] ^ b_q[0] ^ carry_q;

        if (load) begin
            a_d     = a;
            b_d     = b;
            op_d    = '0;
            carry_d = 1'b0;
            cnt_d   = '0;
            state_d = SHIFT;
        end else if (state_q == SHIFT) begin
            carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
            a_d     = {1'b0, a_q[WIDTH-1:1]};
            b_d     = {1'b0, b_q[WIDTH-1:1]};
            op_d    = {sum_bit, op_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
                state_d = DONE;
            end
        end
    end

`ifdef SHIFT_ADDER_DONE_EN
    logic done_q;

    // Completion flag, high exactly while the FSM sits in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= (state_d == DONE);
        end
    end

    assign done = done_q;
`endif

    assign contents_a = a_q;
    assign contents_b = b_q;
    assign op         = op_q;
    assign carry      = carry_q;

endmodule

// File: tb/tb_shift_adder.sv
// Directed-vector bench for shift_adder (WIDTH=16); checks the optional
// done output when SHIFT_ADDER_DONE_EN is defined.
module tb_shift_adder;

    localparam int unsigned WIDTH = 16;

    logic             clk;
    logic             reset;
    logic             load;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] contents_a;
    logic [WIDTH-1:0] contents_b;
    logic [WIDTH-1:0] op;
    logic             carry;
`ifdef SHIFT_ADDER_DONE_EN
    logic             done;
`endif

    int unsigned n_tests;
    int unsigned n_fail;

    shift_adder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .a          (a),
        .b          (b),
        .contents_a (contents_a),
        .contents_b (contents_b),
        .op         (op),
`ifdef SHIFT_ADDER_DONE_EN
        .done       (done),
`endif
        .carry      (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one rising edge, then drop load
    task automatic do_load(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
        load = 1'b1;
        a    = va;
        b    = vb;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_result(input string tag, input logic [WIDTH-1:0] eop, input logic ecarry);
        check({tag, ".op"}, 32'(op), 32'(eop));
        check({tag, ".carry"}, 32'(carry), 32'(ecarry));
        check({tag, ".ca"}, 32'(contents_a), 32'h0);
        check({tag, ".cb"}, 32'(contents_b), 32'h0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b0;
        load    = 1'b0;
        a       = '0;
        b       = '0;

        // Reset values
        clocks(2);
        check("rst.op", 32'(op), 32'h0);
        check("rst.carry", 32'(carry), 32'h0);
        check("rst.ca", 32'(contents_a), 32'h0);
        check("rst.cb", 32'(contents_b), 32'h0);
`ifdef SHIFT_ADDER_DONE_EN
        check("rst.done", 32'(done), 32'h0);
`endif
        reset = 1'b1;
        clocks(1);

        // Basic addition, done timing
        do_load(16'h38A9, 16'hBC99);
        check("v1.load.ca", 32'(contents_a), 32'h38A9);
        check("v1.load.cb", 32'(contents_b), 32'hBC99);
        for (int i = 1; i <= 16; i++) begin
            clocks(1);
`ifdef SHIFT_ADDER_DONE_EN
            check($sformatf("v1.done%0d", i), 32'(done), (i == 16) ? 32'h1 : 32'h0);
`endif
        end
        check_result("v1", 16'hF542, 1'b0);

        // Overflow wraps, carry-out set, result holds in DONE
        do_load(16'hFFFF, 16'h0001);
`ifdef SHIFT_ADDER_DONE_EN
        check("v2.done_after_load", 32'(done), 32'h0);
`endif
        clocks(16);
        check_result("v2", 16'h0000, 1'b1);
        clocks(5);
        check_result("v2.hold", 16'h0000, 1'b1);
`ifdef SHIFT_ADDER_DONE_EN
        check("v2.hold.done", 32'(done), 32'h1);
`endif

        // First step of 1+1, then full result
        do_load(16'h0001, 16'h0001);
        clocks(1);
        check_result("v3.step1", 16'h0000, 1'b1);
        clocks(15);
        check_result("v3", 16'h0002, 1'b0);

        // Load mid-operation aborts and restarts
        do_load(16'h1234, 16'h0F0F);
        clocks(5);
        check("v4.mid.ca", 32'(contents_a), 32'h0091);
        check("v4.mid.cb", 32'(contents_b), 32'h0078);
        do_load(16'h0001, 16'h0002);
        clocks(16);
        check_result("v4", 16'h0003, 1'b0);

        // Load held high keeps reloading, no shifting
        load = 1'b1;
        a    = 16'hA5A5;
        b    = 16'h5A5A;
        clocks(3);
        check("hold_load.ca", 32'(contents_a), 32'hA5A5);
        check("hold_load.cb", 32'(contents_b), 32'h5A5A);
        check("hold_load.op", 32'(op), 32'h0);
        load = 1'b0;
        clocks(16);
        check_result("hold_load", 16'hFFFF, 1'b0);

        // Asynchronous reset between edges mid-shift
        do_load(16'hC3C3, 16'h7E7E);
        clocks(3);
        #2;
        reset = 1'b0;
        #1;
        check_result("async_rst", 16'h0000, 1'b0);
`ifdef SHIFT_ADDER_DONE_EN
        check("async_rst.done", 32'(done), 32'h0);
`endif
        @(negedge clk);
        reset = 1'b1;
        clocks(20);
        check_result("after_rst", 16'h0000, 1'b0);
`ifdef SHIFT_ADDER_DONE_EN
        check("after_rst.done", 32'(done), 32'h0);
`endif

        // Fresh addition after reset recovery
        do_load(16'h8000, 16'h8001);
        clocks(16);
        check_result("v5", 16'h0001, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
